// File: rtl/rr_mux_arbiter_pkg.sv
// rtl/rr_mux_arbiter_pkg.sv - shared types and constants for the round-robin mux arbiter
//
// Purpose: FSM state encoding, requester count, select width and a one-hot helper
//          shared by rr_mux_arbiter and rr_pick4.
// Ports:   none (package).

package rr_mux_arbiter_pkg;

  localparam int NREQ  = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  function automatic logic [NREQ-1:0] onehot4(input logic [SEL_W-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_pick4.sv
// rtl/rr_mux_arbiter_pick4.sv - combinational rotating first-set-bit finder
//
// Purpose: scans req starting at index start, wrapping 3->0, and reports the
//          first set bit.
// Ports:
//   req   in  [3:0]  request vector
//   start in  [1:0]  index where the scan begins
//   found out        at least one request bit is set
//   idx   out [1:0]  index of the first set bit at or after start (0 when !found)

module rr_pick4
  import rr_mux_arbiter_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] start,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  always_comb begin
    logic [SEL_W-1:0] w_pos;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      // 2-bit add wraps naturally, giving the circular scan order
      w_pos = start + SEL_W'(k);
      if (!found && req[w_pos]) begin
        found = 1'b1;
        idx   = w_pos;
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - round-robin arbiter driving a shared 4:1 data mux
//
// Purpose: grants one of four requesters at a time in round-robin order, bounds
//          each grant to HOLD_MAX cycles while others wait, and registers the
//          granted lane to y one cycle after the grant.
// Ports:
//   clk      in                rising-edge clock
//   rst_n    in                asynchronous active-low reset
//   req      in  [3:0]         per-requester request
//   d        in  [4*DATA_W-1:0] data lanes, lane i = d[i*DATA_W +: DATA_W]
//   grant    out [3:0]         registered one-hot grant, zero when idle
//   sel      out [1:0]         registered index of current / last grantee
//   y        out [DATA_W-1:0]  registered copy of the lane granted last cycle
//   y_valid  out               y carries data of an active grant
//   busy     out               FSM is in GRANT

module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int DATA_W   = 1,
  parameter int HOLD_MAX = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DATA_W-1:0]   d,
  output logic [NREQ-1:0]          grant,
  output logic [SEL_W-1:0]         sel,
  output logic [DATA_W-1:0]        y,
  output logic                     y_valid,
  output logic                     busy
);

  localparam logic [3:0] HOLD_C = 4'(HOLD_MAX);

  state_e           r_state, w_state_nxt;
  logic [NREQ-1:0]  r_grant, w_grant_nxt;
  logic [SEL_W-1:0] r_sel,   w_sel_nxt;
  logic [SEL_W-1:0] r_ptr,   w_ptr_nxt;
  logic [3:0]       r_hcnt,  w_hcnt_nxt;
  logic [DATA_W-1:0] r_y;
  logic             r_y_valid;

  logic             w_found;
  logic [SEL_W-1:0] w_idx;
  logic [SEL_W-1:0] w_start;
  logic             w_g_req;
  logic             w_others;
  logic             w_at_max;
  logic             w_release;
  logic [DATA_W-1:0] w_lane;

  // While granted the scan starts just past the current grantee so a forced
  // release can never re-pick it while anyone else is waiting.
  assign w_start   = (r_state == ST_GRANT) ? r_sel + 2'd1 : r_ptr;
  assign w_g_req   = req[r_sel];
  assign w_others  = |(req & ~onehot4(r_sel));
  assign w_at_max  = (r_hcnt == HOLD_C);
  assign w_release = !w_g_req || (w_at_max && w_others);
  assign w_lane    = d[int'(r_sel)*DATA_W +: DATA_W];

  rr_pick4 u_pick (
    .req   (req),
    .start (w_start),
    .found (w_found),
    .idx   (w_idx)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_found) w_state_nxt = ST_GRANT;
      ST_GRANT: if (w_release && !w_found) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // output logic: next values of the grant, select, pointer and hold counter
  always_comb begin
    w_grant_nxt = r_grant;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
    w_hcnt_nxt  = r_hcnt;
    case (r_state)
      ST_IDLE: begin
        w_grant_nxt = '0;
        if (w_found) begin
          w_grant_nxt = onehot4(w_idx);
          w_sel_nxt   = w_idx;
          w_hcnt_nxt  = 4'd1;
          w_ptr_nxt   = w_idx + 2'd1;
        end
      end
      ST_GRANT: begin
        if (w_release) begin
          if (w_found) begin
            // back-to-back handover, no idle bubble
            w_grant_nxt = onehot4(w_idx);
            w_sel_nxt   = w_idx;
            w_hcnt_nxt  = 4'd1;
            w_ptr_nxt   = w_idx + 2'd1;
          end else begin
            w_grant_nxt = '0;
            w_hcnt_nxt  = 4'd0;
            w_ptr_nxt   = r_sel + 2'd1;
          end
        end else if (w_at_max) begin
          // nobody else waiting: keep the grant and start a fresh hold window
          w_hcnt_nxt = 4'd1;
        end else if (r_hcnt < HOLD_C) begin
          w_hcnt_nxt = r_hcnt + 4'd1;
        end
      end
      default: begin
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant   <= '0;
      r_sel     <= '0;
      r_ptr     <= '0;
      r_hcnt    <= '0;
      r_y       <= '0;
      r_y_valid <= 1'b0;
    end else begin
      r_grant   <= w_grant_nxt;
      r_sel     <= w_sel_nxt;
      r_ptr     <= w_ptr_nxt;
      r_hcnt    <= w_hcnt_nxt;
      // data follows the grant that was active during the cycle just ended
      r_y_valid <= |r_grant;
      if (|r_grant) begin
        r_y <= w_lane;
      end
    end
  end

  assign grant   = r_grant;
  assign sel     = r_sel;
  assign y       = r_y;
  assign y_valid = r_y_valid;
  assign busy    = (r_state == ST_GRANT);

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb/tb_rr_mux_arbiter.sv - directed and random self-checking bench for rr_mux_arbiter

module tb_rr_mux_arbiter;

  localparam int DATA_W   = 1;
  localparam int HOLD_MAX = 4;
  localparam int MAX_WAIT = 3 * HOLD_MAX + 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  d;
  logic [3:0]  grant;
  logic [1:0]  sel;
  logic [0:0]  y;
  logic        y_valid;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rr_mux_arbiter #(
    .DATA_W   (DATA_W),
    .HOLD_MAX (HOLD_MAX)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .d       (d),
    .grant   (grant),
    .sel     (sel),
    .y       (y),
    .y_valid (y_valid),
    .busy    (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] e;
    logic [3:0] p_grant, p_req, p_d, flip;
    logic [1:0] p_sel;
    int         wait_cnt [4];

    rst_n = 1'b0;
    req   = 4'b0000;
    d     = 4'b0000;
    repeat (3) tick();
    chk("rst_grant", grant, 0);
    chk("rst_sel", sel, 0);
    chk("rst_y", y, 0);
    chk("rst_yv", y_valid, 0);
    chk("rst_busy", busy, 0);

    rst_n = 1'b1;
    tick();
    chk("idle_grant", grant, 0);
    chk("idle_busy", busy, 0);

    // single requester, lane 1 carries 1
    req = 4'b0010;
    d   = 4'b1010;
    tick();
    chk("single_grant_e1", grant, 4'b0010);
    chk("single_sel_e1", sel, 1);
    chk("single_busy_e1", busy, 1);
    chk("single_yv_e1", y_valid, 0);
    tick();
    chk("single_y_e2", y, 1);
    chk("single_yv_e2", y_valid, 1);
    chk("single_grant_e2", grant, 4'b0010);
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("single_hold", grant, 4'b0010);
    end
    req = 4'b0000;
    tick();
    chk("single_rel_grant", grant, 0);
    chk("single_rel_busy", busy, 0);
    chk("single_rel_yv", y_valid, 1);
    chk("single_rel_y", y, 1);
    d = 4'b0000;
    tick();
    chk("single_yhold_yv", y_valid, 0);
    chk("single_yhold_y", y, 1);
    chk("single_sel_kept", sel, 1);

    // fairness: ptr is 2 after requester 1 released
    req = 4'b1111;
    for (int c = 0; c < 17; c++) begin
      tick();
      e = 4'b0001 << ((2 + c / 4) % 4);
      chk("rr_grant", grant, e);
      chk("rr_busy", busy, 1);
    end
    req = 4'b0000;
    tick();
    chk("rr_idle", grant, 0);

    // early release: ptr is 3, so requester 0 wins the 0011 request
    req = 4'b0011;
    tick();
    chk("early_g0_a", grant, 4'b0001);
    tick();
    chk("early_g0_b", grant, 4'b0001);
    req = 4'b0010;
    tick();
    chk("early_switch", grant, 4'b0010);
    chk("early_switch_sel", sel, 1);
    req = 4'b0000;
    tick();
    chk("early_idle_grant", grant, 0);
    chk("early_idle_busy", busy, 0);
    req = 4'b1011;
    tick();
    chk("ptr_is_2", grant, 4'b1000);
    req = 4'b0000;
    tick();
    req = 4'b1001;
    tick();
    chk("wrap_after_3", grant, 4'b0001);
    req = 4'b0000;
    tick();
    req = 4'b1001;
    tick();
    chk("after_0", grant, 4'b1000);

    // asynchronous reset mid-grant
    req = 4'b0000;
    tick();
    d   = 4'b0100;
    req = 4'b0100;
    tick();
    chk("mid_grant", grant, 4'b0100);
    tick();
    chk("mid_yv", y_valid, 1);
    chk("mid_y", y, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_grant", grant, 0);
    chk("async_sel", sel, 0);
    chk("async_y", y, 0);
    chk("async_yv", y_valid, 0);
    chk("async_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    chk("async_after_release", grant, 0);
    tick();
    chk("post_rst_grant", grant, 4'b0100);
    chk("post_rst_sel", sel, 2);

    // random sweep with sticky requests
    req = 4'b0000;
    tick();
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < 4; i++) flip[i] = ($urandom_range(5) == 0);
      req     = req ^ flip;
      d       = 4'($urandom);
      p_sel   = sel;
      p_grant = grant;
      p_d     = d;
      p_req   = req;
      tick();
      chk("sw_onehot", $onehot0(grant), 1);
      chk("sw_busy", busy, (grant != 4'b0000));
      if (busy) chk("sw_sel", grant, 4'b0001 << sel);
      chk("sw_yv", y_valid, (p_grant != 4'b0000));
      if (y_valid) chk("sw_y", y, p_d[p_sel]);
      for (int i = 0; i < 4; i++) begin
        if (p_req[i] && !grant[i]) wait_cnt[i]++;
        else wait_cnt[i] = 0;
        chk("sw_starve", (wait_cnt[i] > MAX_WAIT), 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
